// File: rtl/execute_sequencer.sv
// Execute-stage sequencer: latches one issued op, drives the external ALU from
// the operand registers, captures the ALU or branch result and holds it until retired.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no op in flight, ready to accept an issue
// EXEC  | op latched, ALU evaluating; result captured at next edge
// HOLD  | result valid on out_*, waiting for out_ready to retire
module execute_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_func,
  input  logic [63:0] in_src_0,
  input  logic [63:0] in_src_1,
  input  logic        in_branch,
  input  logic [1:0]  in_cond,
  input  logic [63:0] in_pc,
  input  logic [63:0] in_offset,
  input  logic [4:0]  in_rd,
  output logic [3:0]  alu_func,
  output logic [63:0] alu_data_0,
  output logic [63:0] alu_data_1,
  input  logic [63:0] alu_data_2,
  input  logic        alu_eq,
  input  logic        alu_ne,
  input  logic        alu_lt,
  input  logic        alu_le,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_redirect,
  output logic [63:0] out_target
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic [3:0]  func_q, func_d;
  logic [63:0] src0_q, src0_d;
  logic [63:0] src1_q, src1_d;
  logic        branch_q, branch_d;
  logic [1:0]  cond_q, cond_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] offset_q, offset_d;
  logic [4:0]  rd_q, rd_d;

  logic [63:0] res_data_q, res_data_d;
  logic [4:0]  res_rd_q, res_rd_d;
  logic        res_redirect_q, res_redirect_d;
  logic [63:0] res_target_q, res_target_d;

  logic        ready_raw;
  logic        latch_op;
  logic        cond_flag;

  always_comb begin
    cond_flag = 1'b0;
    case (cond_q)
      2'd0:    cond_flag = alu_eq;
      2'd1:    cond_flag = alu_ne;
      2'd2:    cond_flag = alu_lt;
      default: cond_flag = alu_le;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    ready_raw      = 1'b0;
    latch_op       = 1'b0;
    res_data_d     = res_data_q;
    res_rd_d       = res_rd_q;
    res_redirect_d = res_redirect_q;
    res_target_d   = res_target_q;

    case (state_q)
      ST_IDLE: begin
        ready_raw = 1'b1;
        if (in_valid) begin
          latch_op = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (branch_q) begin
          res_data_d     = 64'd0;
          res_rd_d       = 5'd0;
          res_redirect_d = cond_flag;
          res_target_d   = pc_q + offset_q;
        end else begin
          res_data_d     = alu_data_2;
          res_rd_d       = rd_q;
          res_redirect_d = 1'b0;
          res_target_d   = 64'd0;
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        ready_raw = out_ready;
        if (out_ready) begin
          // retire and optionally accept the next op on the same edge
          if (in_valid) begin
            latch_op = 1'b1;
            state_d  = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    func_d   = func_q;
    src0_d   = src0_q;
    src1_d   = src1_q;
    branch_d = branch_q;
    cond_d   = cond_q;
    pc_d     = pc_q;
    offset_d = offset_q;
    rd_d     = rd_q;
    if (latch_op) begin
      func_d   = in_func;
      src0_d   = in_src_0;
      src1_d   = in_src_1;
      branch_d = in_branch;
      cond_d   = in_cond;
      pc_d     = in_pc;
      offset_d = in_offset;
      rd_d     = in_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      func_q         <= 4'd0;
      src0_q         <= 64'd0;
      src1_q         <= 64'd0;
      branch_q       <= 1'b0;
      cond_q         <= 2'd0;
      pc_q           <= 64'd0;
      offset_q       <= 64'd0;
      rd_q           <= 5'd0;
      res_data_q     <= 64'd0;
      res_rd_q       <= 5'd0;
      res_redirect_q <= 1'b0;
      res_target_q   <= 64'd0;
    end else begin
      state_q        <= state_d;
      func_q         <= func_d;
      src0_q         <= src0_d;
      src1_q         <= src1_d;
      branch_q       <= branch_d;
      cond_q         <= cond_d;
      pc_q           <= pc_d;
      offset_q       <= offset_d;
      rd_q           <= rd_d;
      res_data_q     <= res_data_d;
      res_rd_q       <= res_rd_d;
      res_redirect_q <= res_redirect_d;
      res_target_q   <= res_target_d;
    end
  end

  // in_ready is gated by rst so it falls the moment reset asserts, not at the next edge
  assign in_ready     = rst & ready_raw;
  assign out_valid    = (state_q == ST_HOLD);
  assign alu_func     = func_q;
  assign alu_data_0   = src0_q;
  assign alu_data_1   = src1_q;
  assign out_data     = res_data_q;
  assign out_rd       = res_rd_q;
  assign out_redirect = res_redirect_q;
  assign out_target   = res_target_q;

endmodule

// File: tb/tb_execute_sequencer.sv
// Self-checking bench for execute_sequencer: behavioural ALU plus a queue-based
// scoreboard that predicts handshakes and results from issued ops.
module tb_execute_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [63:0] in_src_0, in_src_1;
  logic        in_branch;
  logic [1:0]  in_cond;
  logic [63:0] in_pc, in_offset;
  logic [4:0]  in_rd;
  logic [3:0]  alu_func;
  logic [63:0] alu_data_0, alu_data_1, alu_data_2;
  logic        alu_eq, alu_ne, alu_lt, alu_le;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_redirect;
  logic [63:0] out_target;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  func;
    logic [63:0] a;
    logic [63:0] b;
    logic        br;
    logic [1:0]  cond;
    logic [63:0] pc;
    logic [63:0] off;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        redir;
    logic [63:0] target;
  } res_t;

  always #5 clk = ~clk;

  execute_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_src_0(in_src_0), .in_src_1(in_src_1),
    .in_branch(in_branch), .in_cond(in_cond),
    .in_pc(in_pc), .in_offset(in_offset), .in_rd(in_rd),
    .alu_func(alu_func), .alu_data_0(alu_data_0), .alu_data_1(alu_data_1),
    .alu_data_2(alu_data_2),
    .alu_eq(alu_eq), .alu_ne(alu_ne), .alu_lt(alu_lt), .alu_le(alu_le),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd),
    .out_redirect(out_redirect), .out_target(out_target)
  );

  // External ALU model: func 0 is signed set-less-than; others are arbitrary but distinct.
  function automatic logic [63:0] alu_ref(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
    case (f)
      4'd0:    return {63'd0, ($signed(a) < $signed(b))};
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a ^ b;
      default: return (a & ~b) ^ {60'd0, f};
    endcase
  endfunction

  function automatic logic flag_ref(input logic [1:0] c, input logic [63:0] a, input logic [63:0] b);
    case (c)
      2'd0:    return a == b;
      2'd1:    return a != b;
      2'd2:    return $signed(a) < $signed(b);
      default: return $signed(a) <= $signed(b);
    endcase
  endfunction

  assign alu_data_2 = alu_ref(alu_func, alu_data_0, alu_data_1);
  assign alu_eq = (alu_data_0 == alu_data_1);
  assign alu_ne = (alu_data_0 != alu_data_1);
  assign alu_lt = ($signed(alu_data_0) < $signed(alu_data_1));
  assign alu_le = ($signed(alu_data_0) <= $signed(alu_data_1));

  function automatic res_t expect_of(input op_t o);
    res_t r;
    if (o.br) begin
      r.data = 64'd0; r.rd = 5'd0;
      r.redir = flag_ref(o.cond, o.a, o.b);
      r.target = o.pc + o.off;
    end else begin
      r.data = alu_ref(o.func, o.a, o.b); r.rd = o.rd;
      r.redir = 1'b0; r.target = 64'd0;
    end
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.func = 4'($urandom_range(0, 15));
    o.a    = {$urandom, $urandom};
    o.b    = ($urandom_range(0, 3) == 0) ? o.a : {$urandom, $urandom};
    o.br   = ($urandom_range(0, 2) == 0);
    o.cond = 2'($urandom_range(0, 3));
    o.pc   = {$urandom, $urandom};
    o.off  = {$urandom, $urandom};
    o.rd   = 5'($urandom_range(0, 31));
    return o;
  endfunction

  task automatic drive_op(input op_t o);
    in_func = o.func; in_src_0 = o.a; in_src_1 = o.b;
    in_branch = o.br; in_cond = o.cond;
    in_pc = o.pc; in_offset = o.off; in_rd = o.rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    op_t o;
    rst = 1'b0; out_ready = 1'b1;
    o = rand_op(); drive_op(o); in_valid = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %0b want 0", out_redirect); end
    checks++; if ({out_data, out_target, out_rd} !== 133'd0) begin errors++; $display("FAIL reset_outputs data %h target %h rd %0d want 0", out_data, out_target, out_rd); end
    checks++; if ({alu_func, alu_data_0, alu_data_1} !== 132'd0) begin errors++; $display("FAIL reset_alu_drive func %0d d0 %h d1 %h want 0", alu_func, alu_data_0, alu_data_1); end
    in_valid = 1'b0;
  endtask

  // Release reset between edges and issue the signed-lt op on the first edge.
  task automatic test_first_issue_slt();
    op_t o;
    res_t e;
    o = '{func:4'd0, a:64'hFFFF_FFFF_FFFF_FFFF, b:64'd1, br:1'b0, cond:2'd0, pc:64'd0, off:64'd0, rd:5'd5};
    e = expect_of(o);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; drive_op(o); in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_issue_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL slt_exec_valid got %0b want 0", out_valid); end
    checks++; if (alu_data_0 !== o.a || alu_data_1 !== o.b || alu_func !== o.func) begin errors++; $display("FAIL slt_alu_drive d0 %h d1 %h f %0d", alu_data_0, alu_data_1, alu_func); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL slt_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== 64'd1 || out_data !== e.data) begin errors++; $display("FAIL slt_data got %h want 1", out_data); end
    checks++; if (out_rd !== 5'd5) begin errors++; $display("FAIL slt_rd got %0d want 5", out_rd); end
    checks++; if (out_redirect !== 1'b0 || out_target !== 64'd0) begin errors++; $display("FAIL slt_redirect got %0b target %h want 0", out_redirect, out_target); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL slt_retire valid %0b ready %0b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_branch();
    op_t o;
    o = '{func:4'd3, a:64'h10, b:64'h10, br:1'b1, cond:2'd0, pc:64'h1000, off:64'hFFFF_FFFF_FFFF_FFF0, rd:5'd9};
    out_ready = 1'b1; drive_op(o); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL branch_valid got %0b want 1", out_valid); end
    checks++; if (out_redirect !== 1'b1) begin errors++; $display("FAIL branch_redirect got %0b want 1", out_redirect); end
    checks++; if (out_target !== 64'h0FF0) begin errors++; $display("FAIL branch_target got %h want 0ff0", out_target); end
    checks++; if (out_rd !== 5'd0 || out_data !== 64'd0) begin errors++; $display("FAIL branch_rd_data rd %0d data %h want 0", out_rd, out_data); end
    tick();
  endtask

  task automatic test_hold();
    op_t o, o2;
    res_t e;
    o = rand_op(); o.br = 1'b0; o.func = 4'd2;
    e = expect_of(o);
    out_ready = 1'b0; drive_op(o); in_valid = 1'b1;
    tick();
    o2 = rand_op(); drive_op(o2);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_%0d valid %0b ready %0b want 1/0", i, out_valid, in_ready); end
      checks++; if (out_data !== e.data || out_rd !== e.rd || out_redirect !== 1'b0) begin errors++; $display("FAIL hold_data_%0d got %h rd %0d want %h rd %0d", i, out_data, out_rd, e.data, e.rd); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %0b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_retire_idle valid %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    op_t  ops[4];
    res_t exp_r[4];
    int   issued, got, last_cyc;
    for (int i = 0; i < 4; i++) begin ops[i] = rand_op(); exp_r[i] = expect_of(ops[i]); end
    issued = 0; got = 0; last_cyc = -1;
    out_ready = 1'b1; drive_op(ops[0]); in_valid = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (got >= 4 || out_data !== exp_r[got].data || out_rd !== exp_r[got].rd ||
            out_redirect !== exp_r[got].redir || out_target !== exp_r[got].target) begin
          errors++; $display("FAIL b2b_result_%0d got %h/%0d/%0b/%h", got, out_data, out_rd, out_redirect, out_target);
        end
        if (last_cyc >= 0) begin
          checks++; if (cyc - last_cyc != 2) begin errors++; $display("FAIL b2b_spacing got %0d want 2", cyc - last_cyc); end
        end
        last_cyc = cyc; got++;
      end
      if (in_valid && in_ready) issued++;
      tick();
      if (issued < 4) drive_op(ops[issued]);
      else in_valid = 1'b0;
    end
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", got); end
  endtask

  task automatic test_random();
    res_t q[$];
    op_t  cur;
    logic just_issued, exp_valid, exp_ready, acc;
    just_issued = 1'b0;
    cur = rand_op(); drive_op(cur); in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(negedge clk);
      exp_valid = (q.size() > 0) && !just_issued;
      exp_ready = (q.size() == 0) || (exp_valid && out_ready);
      checks++; if (out_valid !== exp_valid || in_ready !== exp_ready) begin errors++; $display("FAIL rand_hs cyc %0d valid %0b ready %0b want %0b %0b", cyc, out_valid, in_ready, exp_valid, exp_ready); end
      if (exp_valid) begin
        checks++;
        if (out_data !== q[0].data || out_rd !== q[0].rd || out_redirect !== q[0].redir || out_target !== q[0].target) begin
          errors++; $display("FAIL rand_result cyc %0d got %h/%0d/%0b/%h want %h/%0d/%0b/%h", cyc, out_data, out_rd, out_redirect, out_target, q[0].data, q[0].rd, q[0].redir, q[0].target);
        end
        if (out_ready) void'(q.pop_front());
      end
      acc = in_valid && exp_ready;
      if (acc) q.push_back(expect_of(cur));
      just_issued = acc;
      tick();
      out_ready = (cyc >= 300) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (!in_valid || acc) begin
        cur = rand_op(); drive_op(cur);
        in_valid = (cyc >= 300) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain left %0d want 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    op_t o;
    o = rand_op(); o.br = 1'b1; o.cond = 2'd0; o.b = o.a;
    out_ready = 1'b0; drive_op(o); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_exec valid %0b ready %0b want 0/0", out_valid, in_ready); end
    checks++; if (alu_data_0 !== 64'd0) begin errors++; $display("FAIL rst_exec_alu got %h want 0", alu_data_0); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_stale cyc %0d valid %0b want 0", i, out_valid); end
    end
    // Same again with the result already held on the outputs.
    drive_op(o); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_redirect !== 1'b0 || out_target !== 64'd0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_hold valid %0b redir %0b target %h ready %0b want 0", out_valid, out_redirect, out_target, in_ready);
    end
    @(negedge clk); rst = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_stale cyc %0d valid %0b want 0", i, out_valid); end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_func = 4'd0; in_src_0 = 64'd0; in_src_1 = 64'd0; in_branch = 1'b0;
    in_cond = 2'd0; in_pc = 64'd0; in_offset = 64'd0; in_rd = 5'd0;
    test_reset();
    test_first_issue_slt();
    test_branch();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
